alu_hs: RTL and testbench

- Parametrised, handshaked successor to the team's 8-bit add/shift ALU.
- Adds configurable width, 8 ops, status flags and a multi-cycle shift-add multiplier.
- Sits between the operand/decode stage and the writeback register.
- Valid/ready on both sides; one operation in flight at a time.

---
 rtl/alu_hs.sv | 188 ++++++++++++++++++
 tb/tb_alu_hs.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_hs.sv
// alu_hs: parametrised valid/ready ALU with status flags.
// One operation in flight; ops 0-6 complete in one cycle, MUL (opcode 7)
// uses a WIDTH-cycle shift-add multiplier when built with ALU_MUL_EN.
// Build option: define ALU_MUL_EN to implement MUL; otherwise opcode 7
// completes immediately with flag_ill set.
module alu_hs #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             sysclk,
   input  logic             sysrst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   imm,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_ill
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
`ifdef ALU_MUL_EN
   localparam logic [2:0] OP_MUL = 3'd7;
`endif

   // response record held stable while DONE
   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             z;
      logic             c;
      logic             v;
      logic             ill;
   } rsp_t;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

   state_t           state, state_nxt;
   logic             rdy_en;   // keeps in_ready low until the first edge after reset
   logic             accept;
   rsp_t             rsp_q, rsp_alu;
   logic [WIDTH:0]   sum, diff, shl_w, shr_w;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
   logic [WIDTH-1:0]   mplier;
   logic [SHW-1:0]     cnt;
   logic               mul_last;

   assign acc_nxt  = mplier[0] ? acc + mcand : acc;
   assign mul_last = (cnt == SHW'(WIDTH - 1));
`endif

   assign accept    = in_valid && in_ready;
   assign in_ready  = (state == IDLE) && rdy_en;
   assign out_valid = (state == DONE);
   assign result    = rsp_q.res;
   assign flag_z    = rsp_q.z;
   assign flag_c    = rsp_q.c;
   assign flag_v    = rsp_q.v;
   assign flag_ill  = rsp_q.ill;

   // single-cycle ops; shifts use one extra bit to catch the last bit shifted out
   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      shl_w   = {1'b0, b} << imm;
      shr_w   = {b, 1'b0} >> imm;
      rsp_alu = '0;
      case (opcode)
         OP_ADD: begin
            rsp_alu.res = sum[WIDTH-1:0];
            rsp_alu.c   = sum[WIDTH];
            rsp_alu.v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            rsp_alu.res = diff[WIDTH-1:0];
            rsp_alu.c   = diff[WIDTH];
            rsp_alu.v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: rsp_alu.res = a & b;
         OP_OR:  rsp_alu.res = a | b;
         OP_XOR: rsp_alu.res = a ^ b;
         OP_SHL: begin
            rsp_alu.res = shl_w[WIDTH-1:0];
            rsp_alu.c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            rsp_alu.res = shr_w[WIDTH:1];
            rsp_alu.c   = shr_w[0];
         end
         default: begin
`ifndef ALU_MUL_EN
            rsp_alu.ill = 1'b1;
`endif
         end
      endcase
      rsp_alu.z = (rsp_alu.res == '0);
   end

   // state register
   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         state  <= IDLE;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef ALU_MUL_EN
               state_nxt = (opcode == OP_MUL) ? BUSY : DONE;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef ALU_MUL_EN
         BUSY: if (mul_last) state_nxt = DONE;
`endif
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // result capture and multiplier iteration
   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         rsp_q  <= '0;
`ifdef ALU_MUL_EN
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
`endif
      end else begin
         if (accept) begin
`ifdef ALU_MUL_EN
            if (opcode == OP_MUL) begin
               acc    <= '0;
               mcand  <= {{WIDTH{1'b0}}, a};
               mplier <= b;
               cnt    <= '0;
            end else
`endif
               rsp_q <= rsp_alu;
         end
`ifdef ALU_MUL_EN
         if (state == BUSY) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
               rsp_q.res <= acc_nxt[WIDTH-1:0];
               rsp_q.z   <= (acc_nxt[WIDTH-1:0] == '0);
               rsp_q.c   <= |acc_nxt[2*WIDTH-1:WIDTH];
               rsp_q.v   <= 1'b0;
               rsp_q.ill <= 1'b0;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_hs.sv
// tb_alu_hs: directed vector table plus hand-written handshake/reset sequences.
module tb_alu_hs;

   logic       sysclk = 1'b0;
   logic       sysrst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic [2:0] imm;
   logic [2:0] opcode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       flag_z, flag_c, flag_v, flag_ill;

   int checks = 0;
   int errors = 0;

   alu_hs #(.WIDTH(8)) dut (
      .sysclk(sysclk), .sysrst_n(sysrst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .imm(imm), .opcode(opcode),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_z(flag_z), .flag_c(flag_c),
      .flag_v(flag_v), .flag_ill(flag_ill)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] imm;
      logic [7:0] res;
      logic [3:0] flg;   // {z, c, v, ill}
      int         lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                          input logic [2:0] vi, input logic [7:0] r, input logic [3:0] f,
                          input int l);
      vec_t v;
      v.op = op; v.a = va; v.b = vb; v.imm = vi; v.res = r; v.flg = f; v.lat = l;
      vecs.push_back(v);
   endtask

   // drive one op with out_ready=1, return result/flags/latency and count in_ready highs while waiting
   task automatic do_op(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                        input logic [2:0] vi, output logic [7:0] r, output logic [3:0] f,
                        output int lat, output int rdy_hi);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge sysclk);
         n++;
      end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; opcode = op; a = va; b = vb; imm = vi;
      @(posedge sysclk);
      @(negedge sysclk);
      in_valid = 1'b0;
      lat = 1;
      rdy_hi = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_hi++;
         @(negedge sysclk);
         lat++;
      end
      r = result;
      f = {flag_z, flag_c, flag_v, flag_ill};
      @(negedge sysclk);
   endtask

   initial begin
      logic [7:0] r;
      logic [3:0] f;
      int lat, rdy_hi, seen;

      // {z,c,v,ill}
      add_vec(3'd0, 8'hF0, 8'h20, 3'd0, 8'h10, 4'b0100, 1);
      add_vec(3'd1, 8'h80, 8'h01, 3'd0, 8'h7F, 4'b0010, 1);
      add_vec(3'd1, 8'h05, 8'h05, 3'd0, 8'h00, 4'b1000, 1);
      add_vec(3'd5, 8'h00, 8'hC1, 3'd2, 8'h04, 4'b0100, 1);
      add_vec(3'd6, 8'h00, 8'h01, 3'd0, 8'h01, 4'b0000, 1);
      add_vec(3'd0, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0010, 1);
      add_vec(3'd0, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b1100, 1);
      add_vec(3'd1, 8'h00, 8'h01, 3'd0, 8'hFF, 4'b0100, 1);
      add_vec(3'd2, 8'hF0, 8'h3C, 3'd0, 8'h30, 4'b0000, 1);
      add_vec(3'd3, 8'hF0, 8'h0F, 3'd0, 8'hFF, 4'b0000, 1);
      add_vec(3'd4, 8'hAA, 8'hAA, 3'd0, 8'h00, 4'b1000, 1);
      add_vec(3'd6, 8'h00, 8'h81, 3'd1, 8'h40, 4'b0100, 1);
      add_vec(3'd5, 8'h00, 8'h01, 3'd7, 8'h80, 4'b0000, 1);
`ifdef ALU_MUL_EN
      add_vec(3'd7, 8'h10, 8'h11, 3'd0, 8'h10, 4'b0100, 9);
      add_vec(3'd7, 8'h0F, 8'h0F, 3'd0, 8'hE1, 4'b0000, 9);
      add_vec(3'd7, 8'h00, 8'hFF, 3'd0, 8'h00, 4'b1000, 9);
`else
      add_vec(3'd7, 8'h10, 8'h11, 3'd0, 8'h00, 4'b1001, 1);
`endif

      // reset state
      sysrst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; imm = '0; opcode = '0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_flags", {28'd0, flag_z, flag_c, flag_v, flag_ill}, 32'd0);
      repeat (2) @(posedge sysclk);
      @(negedge sysclk);
      sysrst_n = 1'b1;
      #1 chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(negedge sysclk);
      chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

      // vector table
      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, r, f, lat, rdy_hi);
         chk($sformatf("v%0d_result", i), {24'd0, r}, {24'd0, vecs[i].res});
         chk($sformatf("v%0d_flags", i), {28'd0, f}, {28'd0, vecs[i].flg});
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_busy_ready", i), rdy_hi, 0);
      end

      // backpressure: XOR held in DONE while a second op waits
      out_ready = 1'b0;
      in_valid = 1'b1; opcode = 3'd4; a = 8'h5A; b = 8'h0F; imm = '0;
      @(posedge sysclk);
      @(negedge sysclk);
      opcode = 3'd0; a = 8'h01; b = 8'h02;   // second op, kept valid
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp%0d_result", k), {24'd0, result}, 32'h55);
         chk($sformatf("bp%0d_flags", k), {28'd0, flag_z, flag_c, flag_v, flag_ill}, 32'd0);
         chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
         @(negedge sysclk);
      end
      out_ready = 1'b1;
      @(negedge sysclk);
      chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge sysclk);
      in_valid = 1'b0;
      chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_second_result", {24'd0, result}, 32'h03);
      @(negedge sysclk);

`ifdef ALU_MUL_EN
      // reset in the middle of a multiply
      in_valid = 1'b1; opcode = 3'd7; a = 8'h10; b = 8'h11;
      @(posedge sysclk);
      @(negedge sysclk);
      in_valid = 1'b0;
      repeat (3) @(negedge sysclk);
      chk("mb_busy_ready", {31'd0, in_ready}, 32'd0);
`else
      // reset while a result is held
      out_ready = 1'b0;
      in_valid = 1'b1; opcode = 3'd4; a = 8'hF0; b = 8'h0F;
      @(posedge sysclk);
      @(negedge sysclk);
      in_valid = 1'b0;
      chk("md_done_valid", {31'd0, out_valid}, 32'd1);
`endif
      sysrst_n = 1'b0;
      #1;
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_result", {24'd0, result}, 32'd0);
      chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge sysclk);
      sysrst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge sysclk);
      chk("mrst_ready_after", {31'd0, in_ready}, 32'd1);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid) seen++;
         @(negedge sysclk);
      end
      chk("mrst_no_stale", seen, 0);
      do_op(3'd0, 8'h03, 8'h04, 3'd0, r, f, lat, rdy_hi);
      chk("post_rst_result", {24'd0, r}, 32'h07);
      chk("post_rst_latency", lat, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
